mem_req_ctrl: RTL and testbench



---
 rtl/mem_req_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding load/store requester for mem_system.
// Optional request timeout is compiled in with `define MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        pipe_stall,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_hit,
  output logic        req_err,
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  input  logic [15:0] DataOut,
  input  logic        Done,
  input  logic        Stall,
  input  logic        CacheHit,
  input  logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       wr_q;
  logic       busy_c, accept_c, issue_c, done_c, timeout_c, abort_c;

  // Elaboration-time guard on the timeout range (8-bit counter).
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_req_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  assign busy_c   = (state != IDLE);
  assign accept_c = (state == IDLE) & req_valid & !resp_valid;
  assign issue_c  = (state == ISSUE) & !Stall;
  // Done only counts once the access has actually been presented.
  assign done_c   = (issue_c | (state == WAIT)) & Done;

`ifdef MEM_REQ_TIMEOUT_EN
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst)           to_cnt <= '0;
    else if (accept_c) to_cnt <= '0;
    else if (busy_c)   to_cnt <= to_cnt + CW'(1);
  end

  assign timeout_c = busy_c & (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // err beats Done; Done beats timeout.
  assign abort_c = (busy_c & err) | (timeout_c & !done_c);

  assign pipe_stall = busy_c | (req_valid & !resp_valid);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational handshake/strobe outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    Rd        = 1'b0;
    Wr        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !resp_valid;
        if (accept_c) state_nxt = ISSUE;
      end
      ISSUE: begin
        Rd = issue_c & !wr_q & !rst;
        Wr = issue_c &  wr_q & !rst;
        if (abort_c || done_c) state_nxt = IDLE;
        else if (!Stall)       state_nxt = WAIT;
      end
      WAIT: begin
        if (abort_c || done_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, response capture and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      Addr       <= '0;
      DataIn     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      resp_valid <= done_c | abort_c;
      if (accept_c) begin
        wr_q   <= req_wr;
        Addr   <= req_addr;
        DataIn <= req_wdata;
      end else if (done_c || abort_c) begin
        Addr   <= '0;
        DataIn <= '0;
      end
      if (abort_c) begin
        resp_rdata <= '0;
        resp_hit   <= 1'b0;
        req_err    <= 1'b1;
      end else if (done_c) begin
        resp_rdata <= wr_q ? DW'(0) : DataOut;
        resp_hit   <= CacheHit;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed table, reset sequences and
// random transactions scored against a cycle-count reference model.
module tb_mem_req_ctrl;

  localparam int TO     = 8;
  localparam int BUDGET = 60;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, pipe_stall, resp_valid, resp_hit, req_err;
  logic [15:0] resp_rdata, Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_sticky = 1'b0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .pipe_stall(pipe_stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit), .req_err(req_err),
    .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr, wdata, rdat;
    int          nstall, ndone;
    logic        hit;
    int          err_at;
    logic        hold;
    int          exp_lat;
    logic [15:0] exp_rdata;
    logic        exp_hit;
    logic        exp_err;
    int          exp_pulses;
  } txn_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic txn_t mk(input logic wr, input logic [15:0] addr, wdata, rdat,
                              input int nstall, ndone, input logic hit, input int err_at,
                              input logic hold, input int lat, input logic [15:0] rdata,
                              input logic ehit, input logic eerr, input int pulses);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdat = rdat;
    t.nstall = nstall; t.ndone = ndone; t.hit = hit; t.err_at = err_at; t.hold = hold;
    t.exp_lat = lat; t.exp_rdata = rdata; t.exp_hit = ehit; t.exp_err = eerr; t.exp_pulses = pulses;
    return t;
  endfunction

  // Cycle 0 = accept, cycle 1 = first ISSUE cycle. Earliest of err / Done /
  // timeout ends the request; response is the cycle after.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    int done_c, err_c, to_c, end_c;
    done_c = 1 + t.nstall + t.ndone;
    err_c  = (t.err_at >= 0) ? 1 + t.err_at : 1 << 20;
    to_c   = TO_EN ? TO : 1 << 20;
    end_c  = done_c;
    if (err_c < end_c) end_c = err_c;
    if (to_c  < end_c) end_c = to_c;
    r.exp_lat    = end_c + 1;
    r.exp_pulses = (1 + t.nstall <= end_c) ? 1 : 0;
    if (err_c != end_c && done_c == end_c) begin
      r.exp_err   = 1'b0;
      r.exp_rdata = t.wr ? 16'h0000 : t.rdat;
      r.exp_hit   = t.hit;
    end else begin
      r.exp_err   = 1'b1;
      r.exp_rdata = 16'h0000;
      r.exp_hit   = 1'b0;
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the response.
  task automatic run_txn(input int id, input txn_t t);
    int rd_cyc = -1, resp_cyc = -1, pulses = 0, wrong = 0;
    int bad_addr = 0, bad_stall = 0, bad_ready = 0;
    logic [15:0] rdata_s = 16'hxxxx, addr_s = 16'hxxxx;
    logic hit_s = 1'bx, ready_s = 1'bx, pst_s = 1'bx;
    req_valid = 1'b1; req_wr = t.wr; req_addr = t.addr; req_wdata = t.wdata;
    Stall = 1'b0; Done = 1'b0; err = 1'b0;
    #1;
    check($sformatf("t%0d_accept_ready", id), 32'(req_ready), 32'd1);
    check($sformatf("t%0d_accept_stall", id), 32'(pipe_stall), 32'd1);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= BUDGET && resp_cyc < 0; cyc++) begin
      if (!t.hold) req_valid = 1'b0;
      Stall    = (cyc <= t.nstall);
      err      = (t.err_at >= 0) && (cyc == 1 + t.err_at);
      Done     = 1'b0;
      DataOut  = 16'($urandom);
      CacheHit = 1'($urandom);
      #1;
      if (Rd || Wr) begin
        pulses++;
        if (rd_cyc < 0) rd_cyc = cyc;
      end
      if (t.wr ? Rd : Wr) wrong++;
      if (rd_cyc >= 0 && cyc == rd_cyc + t.ndone) begin
        Done = 1'b1; DataOut = t.rdat; CacheHit = t.hit;
      end
      #2;
      if (resp_valid) begin
        resp_cyc = cyc; rdata_s = resp_rdata; hit_s = resp_hit;
        ready_s = req_ready; pst_s = pipe_stall; addr_s = Addr;
      end else begin
        if (Addr !== t.addr || DataIn !== t.wdata) bad_addr++;
        if (pipe_stall !== 1'b1) bad_stall++;
        if (req_ready !== 1'b0) bad_ready++;
      end
      @(posedge clk); #1;
    end
    Done = 1'b0; err = 1'b0; Stall = 1'b0;
    exp_sticky = exp_sticky | t.exp_err;
    check($sformatf("t%0d_latency", id), 32'(resp_cyc), 32'(t.exp_lat));
    check($sformatf("t%0d_rdata", id), 32'(rdata_s), 32'(t.exp_rdata));
    check($sformatf("t%0d_hit", id), 32'(hit_s), 32'(t.exp_hit));
    check($sformatf("t%0d_strobes", id), 32'(pulses), 32'(t.exp_pulses));
    check($sformatf("t%0d_wrong_strobe", id), 32'(wrong), 32'd0);
    if (t.exp_pulses == 1)
      check($sformatf("t%0d_strobe_cyc", id), 32'(rd_cyc), 32'(1 + t.nstall));
    check($sformatf("t%0d_addr_stable", id), 32'(bad_addr), 32'd0);
    check($sformatf("t%0d_stall_held", id), 32'(bad_stall), 32'd0);
    check($sformatf("t%0d_ready_busy", id), 32'(bad_ready), 32'd0);
    check($sformatf("t%0d_ready_bubble", id), 32'(ready_s), 32'd0);
    check($sformatf("t%0d_stall_resp", id), 32'(pst_s), 32'd0);
    check($sformatf("t%0d_addr_idle", id), 32'(addr_s), 32'd0);
    check($sformatf("t%0d_req_err", id), 32'(req_err), 32'(exp_sticky));
  endtask

  txn_t vec[10];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    DataOut = '0; Done = 1'b0; Stall = 1'b0; CacheHit = 1'b0; err = 1'b0;

    //        wr addr      wdata     rdat      st dn hit err hold lat rdata     hit e  p
    vec[0] = mk(0, 16'h0040, 16'h0000, 16'hBEEF, 0, 0, 1, -1, 0, 2, 16'hBEEF, 1, 0, 1);
    vec[1] = mk(1, 16'h1002, 16'h1234, 16'hDEAD, 0, 4, 0, -1, 0, 6, 16'h0000, 0, 0, 1);
    vec[2] = mk(0, 16'h2222, 16'h0000, 16'h5A5A, 3, 0, 0, -1, 0, 5, 16'h5A5A, 0, 0, 1);
    vec[3] = mk(0, 16'h0100, 16'h0000, 16'h1111, 0, 1, 1, -1, 1, 3, 16'h1111, 1, 0, 1);
    vec[4] = mk(0, 16'h0102, 16'h0000, 16'h2222, 1, 0, 0, -1, 0, 3, 16'h2222, 0, 0, 1);
    vec[5] = mk(1, 16'hFFFE, 16'hFFFF, 16'h3333, 0, 0, 1, -1, 0, 2, 16'h0000, 1, 0, 1);
    vec[6] = mk(0, 16'h0300, 16'h0000, 16'h7777, 0, 3, 1,  2, 0, 4, 16'h0000, 0, 1, 1);
    vec[7] = mk(1, 16'h0400, 16'hABCD, 16'h4444, 1, 2, 1, -1, 0, 5, 16'h0000, 1, 0, 1);
    vec[8] = mk(0, 16'h0500, 16'h0000, 16'h9999, 0, 2, 1,  2, 0, 4, 16'h0000, 0, 1, 1);
    vec[9] = mk(0, 16'h0600, 16'h0000, 16'h0001, 2, 0, 1,  0, 0, 2, 16'h0000, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({resp_valid, resp_hit, req_err, Rd, Wr, resp_rdata}), 32'd0);
    check("reset_bus", {Addr, DataIn}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_txn(i, vec[i]);
    req_valid = 1'b0;

    // Reset while waiting on Done: request dropped, no response, error cleared.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0ABC; req_wdata = 16'h55AA;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; exp_sticky = 1'b0;
    #1;
    check("rst_wait_ctrl", 32'({resp_valid, resp_hit, req_err, Rd, Wr, resp_rdata}), 32'd0);
    check("rst_wait_bus", {Addr, DataIn}, 32'd0);
    check("rst_wait_stall", 32'(pipe_stall), 32'd0);
    Done = 1'b1; err = 1'b1;
    @(posedge clk); #1; Done = 1'b0; err = 1'b0;
    #1;
    check("idle_ignores", 32'({resp_valid, req_err}), 32'd0);
    @(posedge clk); #1;

    // Reset in the issue cycle must suppress the strobe.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0DEF; req_wdata = 16'h1357;
    @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_gates_strobe", 32'({Rd, Wr}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    #1;
    check("rst_issue_resp", 32'({resp_valid, Addr}), 32'd0);
    @(posedge clk); #1;
    check("rst_issue_noresp", 32'(resp_valid), 32'd0);

`ifdef MEM_REQ_TIMEOUT_EN
    begin
      txn_t t;
      t = model(mk(0, 16'h0777, 16'h0000, 16'h0F0F, 0, 100, 1, -1, 0, 0, 16'h0, 0, 0, 0));
      run_txn(50, t);
    end
`endif

    for (int i = 0; i < 30; i++) begin
      txn_t t;
      t.wr     = 1'($urandom);
      t.addr   = 16'($urandom);
      t.wdata  = 16'($urandom);
      t.rdat   = 16'($urandom);
      t.nstall = int'($urandom_range(0, 4));
      t.ndone  = int'($urandom_range(0, 5));
      t.hit    = 1'($urandom);
      t.err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t.nstall + t.ndone + 1)) : -1;
      t.hold   = 1'($urandom);
      run_txn(100 + i, model(t));
    end
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
